// File: rtl/sram_1r1w_init_bypass.sv
// Single-clock 1R1W SRAM wrapper: hardware zero-init sweep, per-segment write mask,
// write-first read forwarding and a read output held until the next accepted read.
//
// state    | meaning
// ST_INIT  | clearing ram[init_ptr] each cycle; R/W requests are dropped
// ST_READY | array initialised; R/W accepted, init_req restarts the sweep

module sram_1r1w_init_bypass #(
    parameter int  DEPTH    = 512,
    parameter int  WIDTH    = 11,
    parameter int  MASK_SEG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                init_req,
    output logic                ready,
    input  logic                R_en,
    input  logic [AW-1:0]       R_addr,
    output logic                R_valid,
    output logic [WIDTH-1:0]    R_data,
    input  logic                W_en,
    input  logic [AW-1:0]       W_addr,
    input  logic [MASK_SEG-1:0] W_mask,
    input  logic [WIDTH-1:0]    W_data
);

    localparam int SEG_W = WIDTH / MASK_SEG;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    init_ptr;
    logic [AW-1:0]    init_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] w_bits;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rd_fwd;
    logic             r_in_range;
    logic             w_in_range;
    logic             rd_acc;
    logic             wr_acc;

    // Only a non-power-of-2 depth can see addresses past the last entry.
    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign r_in_range = 1'b1;
            assign w_in_range = 1'b1;
        end else begin : g_npow2
            assign r_in_range = (R_addr < AW'(DEPTH));
            assign w_in_range = (W_addr < AW'(DEPTH));
        end
    endgenerate

    for (genvar s = 0; s < MASK_SEG; s++) begin : g_mask
        assign w_bits[s*SEG_W +: SEG_W] = {SEG_W{W_mask[s]}};
    end

    assign ready   = (state == ST_READY);
    assign rd_acc  = ready & R_en;
    assign wr_acc  = ready & W_en & w_in_range;
    assign rd_word = mem[R_addr];

    always_comb begin
        rd_fwd = '0;
        if (r_in_range) begin
            rd_fwd = rd_word;
            if (wr_acc && (W_addr == R_addr)) begin
                rd_fwd = (rd_word & ~w_bits) | (W_data & w_bits);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        case (state)
            ST_INIT: begin
                if (init_req) begin
                    init_ptr_nxt = '0;
                end else if (init_ptr == AW'(DEPTH - 1)) begin
                    state_nxt    = ST_READY;
                    init_ptr_nxt = '0;
                end else begin
                    init_ptr_nxt = init_ptr + AW'(1);
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_nxt    = ST_INIT;
                    init_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_ptr_nxt = '0;
            end
        endcase
    end

    // Array storage carries no reset; the sweep is the only way it gets cleared.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            mem[init_ptr] <= '0;
        end else if (wr_acc) begin
            for (int s = 0; s < MASK_SEG; s++) begin
                if (W_mask[s]) begin
                    mem[W_addr][s*SEG_W +: SEG_W] <= W_data[s*SEG_W +: SEG_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R_valid <= 1'b0;
            R_data  <= '0;
        end else begin
            R_valid <= rd_acc;
            if (rd_acc) begin
                R_data <= rd_fwd;
            end
        end
    end

endmodule

// File: tb/tb_sram_1r1w_init_bypass.sv
// Bench for sram_1r1w_init_bypass: a 512x11 single-segment instance and a 300x8
// two-segment instance, both checked against a behavioural array model.

module tb_sram_1r1w_init_bypass;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        init_req [2];
    logic        r_en     [2];
    logic        w_en     [2];
    logic [8:0]  r_addr   [2];
    logic [8:0]  w_addr   [2];
    logic [1:0]  w_mask   [2];
    logic [10:0] w_data   [2];
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [10:0] rd0;
    logic [7:0]  rd1;

    always #5 clock = ~clock;

    sram_1r1w_init_bypass #(.DEPTH(512), .WIDTH(11), .MASK_SEG(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req[0]), .ready(rdy[0]),
        .R_en(r_en[0]), .R_addr(r_addr[0]), .R_valid(rv[0]), .R_data(rd0),
        .W_en(w_en[0]), .W_addr(w_addr[0]), .W_mask(w_mask[0][0:0]), .W_data(w_data[0])
    );

    sram_1r1w_init_bypass #(.DEPTH(300), .WIDTH(8), .MASK_SEG(2)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req[1]), .ready(rdy[1]),
        .R_en(r_en[1]), .R_addr(r_addr[1]), .R_valid(rv[1]), .R_data(rd1),
        .W_en(w_en[1]), .W_addr(w_addr[1]), .W_mask(w_mask[1]), .W_data(w_data[1][7:0])
    );

    int          dep  [2];
    int          segw [2];
    int          nseg [2];
    logic [10:0] mdl  [2][512];
    bit          mready [2];
    int          left   [2];
    logic        exp_rv [2];
    logic [10:0] exp_rd [2];
    int          n_vec;
    int          n_err;

    function automatic logic [10:0] obs_rd(int i);
        return (i == 0) ? rd0 : {3'b000, rd1};
    endfunction

    function automatic logic [10:0] mbits(int i, logic [1:0] m);
        logic [10:0] b;
        b = '0;
        for (int s = 0; s < nseg[i]; s++)
            for (int k = 0; k < segw[i]; k++)
                if (m[s]) b[s*segw[i] + k] = 1'b1;
        return b;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            init_req[i] = 1'b0; r_en[i] = 1'b0; w_en[i] = 1'b0;
            r_addr[i] = '0; w_addr[i] = '0; w_mask[i] = '0; w_data[i] = '0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mready[i] = 1'b0; left[i] = dep[i]; exp_rv[i] = 1'b0; exp_rd[i] = '0;
        end
    endtask

    // One clock: model the cycle's effect, take the edge, sample 1 time unit later.
    task automatic step();
        logic [10:0] v;
        logic [10:0] b;
        for (int i = 0; i < 2; i++) begin
            b = mbits(i, w_mask[i]);
            if (mready[i]) begin
                if (r_en[i]) begin
                    v = '0;
                    if (int'(r_addr[i]) < dep[i]) begin
                        v = mdl[i][r_addr[i]];
                        if (w_en[i] && w_addr[i] == r_addr[i]) v = (v & ~b) | (w_data[i] & b);
                    end
                    exp_rv[i] = 1'b1;
                    exp_rd[i] = v;
                end else begin
                    exp_rv[i] = 1'b0;
                end
                if (w_en[i] && int'(w_addr[i]) < dep[i])
                    mdl[i][w_addr[i]] = (mdl[i][w_addr[i]] & ~b) | (w_data[i] & b);
                if (init_req[i]) begin
                    mready[i] = 1'b0;
                    left[i]   = dep[i];
                end
            end else begin
                exp_rv[i] = 1'b0;
                if (init_req[i]) begin
                    left[i] = dep[i];
                end else begin
                    left[i]--;
                    if (left[i] == 0) begin
                        mready[i] = 1'b1;
                        for (int a = 0; a < dep[i]; a++) mdl[i][a] = '0;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        #2;
        assert_reset();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (rdy[i] !== 1'b0 || rv[i] !== 1'b0 || obs_rd(i) !== 11'h000) begin
                n_err++;
                $display("FAIL reset_vals[%0d]: ready=%b R_valid=%b R_data=%h, want 0/0/000", i, rdy[i], rv[i], obs_rd(i));
            end
        end
        release_reset();
    endtask

    task automatic test_sweep();
        int cyc0 = 0;
        int cyc1 = 0;
        for (int k = 1; k <= 600 && !rdy[0]; k++) begin
            step();
            if (rdy[1] && cyc1 == 0) cyc1 = k;
            if (rdy[0]) cyc0 = k;
        end
        n_vec++;
        if (cyc0 != 512) begin
            n_err++;
            $display("FAIL sweep_len0: ready rose after %0d cycles, want 512", cyc0);
        end
        n_vec++;
        if (cyc1 != 300) begin
            n_err++;
            $display("FAIL sweep_len1: ready rose after %0d cycles, want 300", cyc1);
        end
        for (int a = 0; a < 512; a++) begin
            r_en[0] = 1'b1; r_addr[0] = 9'(a);
            r_en[1] = (a < 300); r_addr[1] = 9'(a);
            step();
            for (int i = 0; i < 2; i++) begin
                if (i == 1 && a >= 300) continue;
                n_vec++;
                if (rv[i] !== 1'b1 || obs_rd(i) !== 11'h000 || rdy[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL zero_read[%0d] addr %0d: R_valid=%b R_data=%h ready=%b, want 1/000/1", i, a, rv[i], obs_rd(i), rdy[i]);
                end
            end
        end
    endtask

    task automatic test_write_read_hold();
        w_en[0] = 1'b1; w_addr[0] = 9'd3; w_mask[0] = 2'b01; w_data[0] = 11'h5A5;
        step();
        r_en[0] = 1'b1; r_addr[0] = 9'd3;
        step();
        n_vec++;
        if (rv[0] !== 1'b1 || rd0 !== 11'h5A5 || rd0 !== exp_rd[0]) begin
            n_err++;
            $display("FAIL wr_rd_addr3: R_valid=%b R_data=%h, want 1/5a5", rv[0], rd0);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (rv[0] !== 1'b0 || rd0 !== 11'h5A5) begin
                n_err++;
                $display("FAIL hold_idle cycle %0d: R_valid=%b R_data=%h, want 0/5a5", k, rv[0], rd0);
            end
        end
        w_en[0] = 1'b1; w_addr[0] = 9'd3; w_mask[0] = 2'b01; w_data[0] = 11'h111;
        step();
        n_vec++;
        if (rv[0] !== 1'b0 || rd0 !== 11'h5A5) begin
            n_err++;
            $display("FAIL hold_after_write: R_valid=%b R_data=%h, want 0/5a5", rv[0], rd0);
        end
        r_en[0] = 1'b1; r_addr[0] = 9'd3;
        step();
        n_vec++;
        if (rv[0] !== 1'b1 || rd0 !== 11'h111) begin
            n_err++;
            $display("FAIL reread_addr3: R_valid=%b R_data=%h, want 1/111", rv[0], rd0);
        end
    endtask

    task automatic test_mask_forward();
        w_en[1] = 1'b1; w_addr[1] = 9'd7; w_mask[1] = 2'b11; w_data[1] = 11'h0AB;
        step();
        w_en[1] = 1'b1; w_addr[1] = 9'd7; w_mask[1] = 2'b01; w_data[1] = 11'h034;
        r_en[1] = 1'b1; r_addr[1] = 9'd7;
        step();
        n_vec++;
        if (rv[1] !== 1'b1 || rd1 !== 8'hA4 || {3'b000, rd1} !== exp_rd[1]) begin
            n_err++;
            $display("FAIL fwd_masked: R_valid=%b R_data=%h, want 1/a4", rv[1], rd1);
        end
        r_en[1] = 1'b1; r_addr[1] = 9'd7;
        step();
        n_vec++;
        if (rv[1] !== 1'b1 || rd1 !== 8'hA4) begin
            n_err++;
            $display("FAIL masked_reread: R_valid=%b R_data=%h, want 1/a4", rv[1], rd1);
        end
    endtask

    task automatic test_init_req();
        int cyc = 0;
        for (int a = 0; a < 10; a++) begin
            w_en[0] = 1'b1; w_addr[0] = 9'(a); w_mask[0] = 2'b01; w_data[0] = 11'h7FF;
            step();
        end
        r_en[0] = 1'b1; r_addr[0] = 9'd9;
        w_en[0] = 1'b1; w_addr[0] = 9'd10; w_mask[0] = 2'b01; w_data[0] = 11'h123;
        init_req[0] = 1'b1;
        step();
        n_vec++;
        if (rdy[0] !== 1'b0 || rv[0] !== 1'b1 || rd0 !== 11'h7FF) begin
            n_err++;
            $display("FAIL init_req_cycle: ready=%b R_valid=%b R_data=%h, want 0/1/7ff", rdy[0], rv[0], rd0);
        end
        for (int k = 1; k <= 600 && !rdy[0]; k++) begin
            r_en[0] = 1'b1; r_addr[0] = 9'($urandom_range(0, 15));
            w_en[0] = 1'b1; w_addr[0] = 9'($urandom_range(0, 15));
            w_mask[0] = 2'b01; w_data[0] = 11'($urandom);
            step();
            n_vec++;
            if (rv[0] !== 1'b0 || rd0 !== 11'h7FF) begin
                n_err++;
                $display("FAIL sweep_ignores_rw cycle %0d: R_valid=%b R_data=%h, want 0/7ff", k, rv[0], rd0);
            end
            if (rdy[0]) cyc = k;
        end
        n_vec++;
        if (cyc != 512) begin
            n_err++;
            $display("FAIL init_req_sweep_len: ready rose after %0d cycles, want 512", cyc);
        end
        for (int a = 0; a <= 10; a++) begin
            r_en[0] = 1'b1; r_addr[0] = 9'(a);
            step();
            n_vec++;
            if (rv[0] !== 1'b1 || rd0 !== 11'h000) begin
                n_err++;
                $display("FAIL cleared_addr %0d: R_valid=%b R_data=%h, want 1/000", a, rv[0], rd0);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc = 0;
        w_en[0] = 1'b1; w_addr[0] = 9'd1; w_mask[0] = 2'b01; w_data[0] = 11'h2AA;
        step();
        r_en[0] = 1'b1; r_addr[0] = 9'd1;
        step();
        init_req[0] = 1'b1;
        step();
        repeat (199) step();
        n_vec++;
        if (rdy[0] !== 1'b0 || rd0 !== 11'h2AA) begin
            n_err++;
            $display("FAIL mid_sweep_hold: ready=%b R_data=%h, want 0/2aa", rdy[0], rd0);
        end
        assert_reset();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (rdy[i] !== 1'b0 || rv[i] !== 1'b0 || obs_rd(i) !== 11'h000) begin
                n_err++;
                $display("FAIL async_reset[%0d]: ready=%b R_valid=%b R_data=%h, want 0/0/000", i, rdy[i], rv[i], obs_rd(i));
            end
        end
        release_reset();
        for (int k = 1; k <= 600 && !rdy[0]; k++) begin
            step();
            if (rdy[0]) cyc = k;
        end
        n_vec++;
        if (cyc != 512) begin
            n_err++;
            $display("FAIL resweep_len: ready rose after %0d cycles, want 512", cyc);
        end
    endtask

    task automatic test_out_of_range();
        w_en[1] = 1'b1; w_addr[1] = 9'd7; w_mask[1] = 2'b11; w_data[1] = 11'h05C;
        step();
        w_en[1] = 1'b1; w_addr[1] = 9'd299; w_mask[1] = 2'b11; w_data[1] = 11'h011;
        r_en[1] = 1'b1; r_addr[1] = 9'd7;
        step();
        n_vec++;
        if (rv[1] !== 1'b1 || rd1 !== 8'h5C) begin
            n_err++;
            $display("FAIL oor_setup: R_valid=%b R_data=%h, want 1/5c", rv[1], rd1);
        end
        w_en[1] = 1'b1; w_addr[1] = 9'd310; w_mask[1] = 2'b11; w_data[1] = 11'h0FF;
        r_en[1] = 1'b1; r_addr[1] = 9'd310;
        step();
        n_vec++;
        if (rv[1] !== 1'b1 || rd1 !== 8'h00) begin
            n_err++;
            $display("FAIL oor_read_fwd: R_valid=%b R_data=%h, want 1/00", rv[1], rd1);
        end
        for (int a = 0; a < 300; a++) begin
            r_en[1] = 1'b1; r_addr[1] = 9'(a);
            step();
            n_vec++;
            if (rv[1] !== 1'b1 || {3'b000, rd1} !== exp_rd[1]) begin
                n_err++;
                $display("FAIL oor_unchanged addr %0d: R_valid=%b R_data=%h, want 1/%h", a, rv[1], rd1, exp_rd[1]);
            end
        end
        r_en[1] = 1'b1; r_addr[1] = 9'd310;
        step();
        n_vec++;
        if (rv[1] !== 1'b1 || rd1 !== 8'h00) begin
            n_err++;
            $display("FAIL oor_read: R_valid=%b R_data=%h, want 1/00", rv[1], rd1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                w_en[i]   = 1'($urandom_range(0, 1));
                r_en[i]   = 1'($urandom_range(0, 1));
                w_mask[i] = 2'($urandom);
                w_data[i] = (i == 0) ? 11'($urandom) : {3'b000, 8'($urandom)};
                if (i == 0)
                    w_addr[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
                else
                    w_addr[i] = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(290, 319)) : 9'($urandom_range(0, 15));
                r_addr[i]   = ($urandom_range(0, 1) == 0) ? w_addr[i] : 9'($urandom_range(0, 15));
                init_req[i] = ($urandom_range(0, 999) == 0);
            end
            step();
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (rdy[i] !== mready[i] || rv[i] !== exp_rv[i] || obs_rd(i) !== exp_rd[i]) begin
                    n_err++;
                    $display("FAIL random[%0d] cycle %0d: ready=%b R_valid=%b R_data=%h, want %b/%b/%h", i, k, rdy[i], rv[i], obs_rd(i), mready[i], exp_rv[i], exp_rd[i]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        dep[0] = 512; segw[0] = 11; nseg[0] = 1;
        dep[1] = 300; segw[1] = 4;  nseg[1] = 2;
        test_reset();
        test_sweep();
        test_write_read_hold();
        test_mask_forward();
        test_init_req();
        test_reset_mid_sweep();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
